// File: rtl/usb_rx_pkg.sv
// ============================================================================
// usb_rx_pkg : shared types, PID codes and PID helpers for the USB RX path.
// Rev 1.0
// ============================================================================
`default_nettype none

package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PID     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_READY   = 3'd3,
    ST_DROP    = 3'd4
  } state_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  // Upper nibble of a PID byte is the one's complement of the lower nibble.
  function automatic logic pid_byte_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_rx_byte_fifo.sv
// ============================================================================
// usb_rx_byte_fifo : single-clock byte FIFO with push/pop/flush and occupancy.
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_rx_byte_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [7:0]       wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [7:0]       rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_push_ok = push_i & ~full_o & ~flush_i;
  assign w_pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/usb_rx_packet_assembler.sv
// ============================================================================
// usb_rx_packet_assembler : PID check, payload buffering and packet hand-off.
// Optional CRC16 stripping on DATA0/DATA1 via USB_RX_ASM_CRC_STRIP_EN. Rev 1.0
// ============================================================================
`default_nettype none

module usb_rx_packet_assembler
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             write_enable,
  input  logic             rcv_error,
  input  logic             pkt_end,
  output logic             pkt_valid,
  output logic [3:0]       pkt_pid,
  output logic [CNT_W-1:0] pkt_len,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  input  logic             pkt_done,
  output logic             pkt_error,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [7:0]       pid_byte_q, pid_byte_d;
  logic [3:0]       pkt_pid_q, pkt_pid_d;
  logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_error_q, pkt_error_d;
  logic             end_seen_q, end_seen_d;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             drop_req, end_req;
`ifdef USB_RX_ASM_CRC_STRIP_EN
  logic [3:0]       w_end_pid;
`endif

  usb_rx_byte_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (rx_data),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (rd_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pid_byte_q  <= '0;
      pkt_pid_q   <= '0;
      pkt_len_q   <= '0;
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      end_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_byte_q  <= pid_byte_d;
      pkt_pid_q   <= pkt_pid_d;
      pkt_len_q   <= pkt_len_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_error_q <= pkt_error_d;
      end_seen_q  <= end_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pid_byte_d  = pid_byte_q;
    pkt_pid_d   = pkt_pid_q;
    pkt_len_d   = pkt_len_q;
    pkt_valid_d = pkt_valid_q;
    pkt_error_d = 1'b0;
    end_seen_d  = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    drop_req    = 1'b0;
    end_req     = 1'b0;
`ifdef USB_RX_ASM_CRC_STRIP_EN
    w_end_pid   = (state_q == ST_PID) ? pid_byte_q[3:0] : pkt_pid_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          pid_byte_d = rx_data;
          state_d    = ST_PID;
        end
      end
      ST_PID: begin
        if (rcv_error || !pid_byte_ok(pid_byte_q)) begin
          drop_req = 1'b1;
        end else begin
          pkt_pid_d = pid_byte_q[3:0];
          if (pkt_end) begin
            end_req = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rcv_error || (write_enable && fifo_full)) begin
          drop_req = 1'b1;
        end else if (pkt_end) begin
          end_req = 1'b1;
        end else if (write_enable) begin
          fifo_push = 1'b1;
        end
      end
      ST_READY: begin
        // A byte arriving before release is lost; the held packet stays intact.
        pkt_error_d = write_enable;
        if (pkt_done) begin
          fifo_flush  = 1'b1;
          pkt_valid_d = 1'b0;
          pkt_len_d   = '0;
          state_d     = ST_IDLE;
        end else if (rd_en && (pkt_len_q != '0) && !fifo_empty) begin
          fifo_pop  = 1'b1;
          pkt_len_d = pkt_len_q - CNT_W'(1);
        end
      end
      ST_DROP: begin
        fifo_flush = 1'b1;
        if (pkt_end || end_seen_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (end_req) begin
`ifdef USB_RX_ASM_CRC_STRIP_EN
      if (is_data_pid(w_end_pid)) begin
        if (fifo_count < CNT_W'(2)) begin
          drop_req = 1'b1;
        end else begin
          state_d     = ST_READY;
          pkt_valid_d = 1'b1;
          pkt_len_d   = fifo_count - CNT_W'(2);
        end
      end else begin
        state_d     = ST_READY;
        pkt_valid_d = 1'b1;
        pkt_len_d   = fifo_count;
      end
`else
      state_d     = ST_READY;
      pkt_valid_d = 1'b1;
      pkt_len_d   = fifo_count;
`endif
    end

    // Remember an EOP seen on the drop cycle so DROP exits without waiting.
    if (drop_req) begin
      state_d     = ST_DROP;
      pkt_error_d = 1'b1;
      fifo_flush  = 1'b1;
      end_seen_d  = pkt_end;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_pid   = pkt_pid_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_error = pkt_error_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_packet_assembler.sv
// ============================================================================
// tb_usb_rx_packet_assembler : directed vector table plus corner-case sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_usb_rx_packet_assembler;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef USB_RX_ASM_CRC_STRIP_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             write_enable, rcv_error, pkt_end, rd_en, pkt_done;
  logic             pkt_valid, pkt_error, busy;
  logic [3:0]       pkt_pid;
  logic [CNT_W-1:0] pkt_len;
  logic [7:0]       rd_data;

  usb_rx_packet_assembler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .write_enable (write_enable),
    .rcv_error    (rcv_error),
    .pkt_end      (pkt_end),
    .pkt_valid    (pkt_valid),
    .pkt_pid      (pkt_pid),
    .pkt_len      (pkt_len),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .pkt_done     (pkt_done),
    .pkt_error    (pkt_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  bit valid_seen = 1'b0;

  always @(negedge clk) begin
    if (pkt_error === 1'b1) err_pulses++;
    if (pkt_valid === 1'b1) valid_seen = 1'b1;
  end

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       pend;
    logic       rd;
    logic       done;
    logic       vld;
    logic [3:0] pid;
    int         len;
    logic       perr;
    logic       bsy;
    logic       chk_rd;
    logic [7:0] rdat;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic we, logic [7:0] d, logic pend, logic rd, logic done,
                              logic vld, logic [3:0] pid, int len, logic perr, logic bsy,
                              logic chk_rd, logic [7:0] rdat);
    vec_t v;
    v.we = we; v.d = d; v.pend = pend; v.rd = rd; v.done = done;
    v.vld = vld; v.pid = pid; v.len = len; v.perr = perr; v.bsy = bsy;
    v.chk_rd = chk_rd; v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] d, input logic pend,
                     input logic rd, input logic done, input logic err);
    write_enable = we; rx_data = d; pkt_end = pend;
    rd_en = rd; pkt_done = done; rcv_error = err;
    @(posedge clk);
    #1;
    write_enable = 1'b0; pkt_end = 1'b0; rd_en = 1'b0;
    pkt_done = 1'b0; rcv_error = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic eop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic done();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int e0;

  initial begin
    // DATA0 packet 0xC3 + 11 22 33; with CRC stripping only 0x11 remains.
    tbl[0]  = mk(1, 8'hC3, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0, 8'h00);
    tbl[2]  = mk(1, 8'h11, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0, 8'h00);
    tbl[3]  = mk(1, 8'h22, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0, 8'h00);
    tbl[4]  = mk(1, 8'h33, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0, 8'h00);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0, 1, 4'h3, CRC ? 1 : 3, 0, 1, 1, 8'h11);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 1, 4'h3, CRC ? 0 : 2, 0, 1, 1, 8'h22);
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, 1, 4'h3, CRC ? 0 : 1, 0, 1, 1, CRC ? 8'h22 : 8'h33);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 1, 4'h3, 0, 0, 1, CRC, 8'h22);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 1, 4'h3, 0, 0, 1, CRC, 8'h22);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 0, 4'h3, 0, 0, 0, 0, 8'h00);

    rst = 1'b1; rx_data = '0; write_enable = 0; rcv_error = 0;
    pkt_end = 0; rd_en = 0; pkt_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_pid", pkt_pid, 0);
    chk("rst_len", pkt_len, 0);
    chk("rst_err", pkt_error, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].we, tbl[i].d, tbl[i].pend, tbl[i].rd, tbl[i].done, 1'b0);
      chk($sformatf("t%0d_valid", i), pkt_valid, tbl[i].vld);
      chk($sformatf("t%0d_pid", i), pkt_pid, tbl[i].pid);
      chk($sformatf("t%0d_len", i), pkt_len, tbl[i].len);
      chk($sformatf("t%0d_err", i), pkt_error, tbl[i].perr);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      if (tbl[i].chk_rd) chk($sformatf("t%0d_rdata", i), rd_data, tbl[i].rdat);
    end

    // Bad PID complement: one error pulse, never valid, idle after EOP.
    idle();
    valid_seen = 1'b0; e0 = err_pulses;
    byte_in(8'hC4);
    idle();
    chk("badpid_err", pkt_error, 1);
    byte_in(8'hAA);
    chk("badpid_err_once", pkt_error, 0);
    byte_in(8'hBB);
    eop();
    chk("badpid_busy", busy, 0);
    idle();
    chk("badpid_pulses", err_pulses - e0, 1);
    chk("badpid_novalid", valid_seen, 0);

    // Overflow: four bytes fill DEPTH=4, the fifth drops the packet.
    e0 = err_pulses;
    byte_in(8'h4B);
    idle();
    for (int i = 0; i < 4; i++) byte_in(8'h50 + 8'(i));
    chk("ovf_full_noerr", pkt_error, 0);
    byte_in(8'h54);
    chk("ovf_err", pkt_error, 1);
    eop();
    chk("ovf_busy", busy, 0);
    idle();
    chk("ovf_pulses", err_pulses - e0, 1);

    // Exactly DEPTH bytes after the overflow: FIFO must start empty.
    byte_in(8'h69);
    idle();
    for (int i = 0; i < 4; i++) byte_in(8'hA0 + 8'(i));
    eop();
    chk("full_valid", pkt_valid, 1);
    chk("full_pid", pkt_pid, 4'h9);
    chk("full_len", pkt_len, 4);
    chk("full_rd0", rd_data, 8'hA0);
    for (int i = 1; i < 4; i++) begin
      rd();
      chk($sformatf("full_rd%0d", i), rd_data, 8'hA0 + 8'(i));
    end
    rd();
    chk("full_len_end", pkt_len, 0);
    done();

    // rcv_error with the second payload byte, then zero-length ACK.
    e0 = err_pulses;
    byte_in(8'h5A);
    idle();
    byte_in(8'h01);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rxerr_err", pkt_error, 1);
    chk("rxerr_busy", busy, 1);
    eop();
    chk("rxerr_idle", busy, 0);
    byte_in(8'hD2);
    idle();
    eop();
    chk("ack_valid", pkt_valid, 1);
    chk("ack_pid", pkt_pid, 4'h2);
    chk("ack_len", pkt_len, 0);
    chk("rxerr_pulses", err_pulses - e0, 1);
    done();
    chk("ack_released", pkt_valid, 0);

    // Partial read, early byte while held, release with rd_en ignored.
    byte_in(8'h69);
    idle();
    byte_in(8'hA1); byte_in(8'hA2); byte_in(8'hA3);
    eop();
    chk("rel_len", pkt_len, 3);
    rd();
    chk("rel_rd", rd_data, 8'hA2);
    chk("rel_len1", pkt_len, 2);
    byte_in(8'hEE);
    chk("rel_early_err", pkt_error, 1);
    chk("rel_held_len", pkt_len, 2);
    chk("rel_held_rd", rd_data, 8'hA2);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rel_valid", pkt_valid, 0);
    chk("rel_len0", pkt_len, 0);
    chk("rel_busy", busy, 0);
    byte_in(8'h69);
    idle();
    byte_in(8'hB1); byte_in(8'hB2);
    eop();
    chk("next_len", pkt_len, 2);
    chk("next_rd", rd_data, 8'hB1);
    done();

    // Reset in the middle of a payload.
    byte_in(8'h4B);
    idle();
    byte_in(8'h77);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_valid", pkt_valid, 0);
    chk("mrst_pid", pkt_pid, 0);
    chk("mrst_len", pkt_len, 0);
    chk("mrst_err", pkt_error, 0);
    chk("mrst_busy", busy, 0);
    byte_in(8'h69);
    idle();
    byte_in(8'hC5);
    eop();
    chk("post_valid", pkt_valid, 1);
    chk("post_pid", pkt_pid, 4'h9);
    chk("post_len", pkt_len, 1);
    chk("post_rd", rd_data, 8'hC5);
    done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_rx_packet_assembler.md
Name: usb_rx_packet_assembler

Overview:
- Downstream stage of the USB receiver. Consumes its per-byte write strobes, error flag and end-of-packet strobe.
- Validates the PID byte and buffers payload bytes in an internal FIFO.
- Presents each complete, error-free packet to the miner control logic as pid + byte count + byte-read port.
- Bad packets are discarded whole and reported with a one-cycle error pulse.

Parameters:
- DEPTH, 64, payload FIFO depth in bytes; power of two, 4..256.
- CNT_W, $clog2(DEPTH)+1, width of byte counts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  byte from receiver shift register
- write_enable  in  1  one-cycle strobe: rx_data holds a new byte
- rcv_error  in  1  receiver error level; sampled every cycle
- pkt_end  in  1  one-cycle end-of-packet strobe (EOP from receiver)
- pkt_valid  out  1  complete good packet available
- pkt_pid  out  4  PID[3:0] of available packet
- pkt_len  out  CNT_W  payload bytes remaining to read
- rd_en  in  1  pop one payload byte
- rd_data  out  8  current FIFO head byte, combinational from storage
- pkt_done  in  1  consumer releases packet; discards any unread bytes
- pkt_error  out  1  one-cycle pulse: packet dropped
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset, synchronous, highest priority: state=IDLE, FIFO pointers=0, pkt_valid=0, pkt_pid=0, pkt_len=0, pkt_error=0, busy=0. Reset mid-packet discards everything.
- States: IDLE, PID, PAYLOAD, READY, DROP.
- IDLE:
  - write_enable -> treat byte as PID; go PID for the check.
  - pkt_end while in IDLE is ignored.
- PID check, one cycle:
  - rx_data[7:4] must equal ~rx_data[3:0].
  - Pass -> latch pkt_pid, go PAYLOAD.
  - Fail -> go DROP.
- PAYLOAD:
  - Each write_enable pushes rx_data; write pointer wraps modulo DEPTH.
  - Push while DEPTH bytes already stored -> overflow -> DROP.
  - pkt_end -> READY. pkt_valid rises the cycle after pkt_end, with pkt_len = bytes stored.
  - Zero-payload packets (handshake/token-less) are legal with pkt_len=0.
- rcv_error high in PID or PAYLOAD -> DROP.
- Same-cycle priority, highest first: rcv_error, overflow, pkt_end, write_enable.
- DROP:
  - Flush FIFO pointers to 0 on entry.
  - Pulse pkt_error exactly once, on the entry cycle.
  - Ignore write_enable; wait for pkt_end -> IDLE.
  - If DROP is entered on a pkt_end cycle, return to IDLE next cycle.
- READY:
  - pkt_valid=1.
  - rd_en with pkt_len>0 advances the read pointer and decrements pkt_len next cycle.
  - rd_en with pkt_len=0 is ignored.
  - pkt_done -> flush pointers, pkt_valid=0 next cycle, IDLE. rd_en in the same cycle is ignored.
  - write_enable while in READY (new packet before release) -> pkt_error pulse, byte lost, stay READY. The held packet is untouched.
- Latency: pkt_end to pkt_valid = 1 cycle. rd_en to next rd_data = 1 cycle.
- Reads and writes never overlap, since only one packet is resident. FIFO is full when count==DEPTH and empty when count==0.

Optional Feature:
- Macro USB_RX_ASM_CRC_STRIP_EN.
- Defined:
  - On pkt_end for DATA0/DATA1 PIDs (0011, 1011), the last 2 stored bytes (CRC16) are removed from the packet; pkt_len = stored-2.
  - Fewer than 2 bytes stored -> DROP with pkt_error.
  - Other PIDs are unchanged.
- Undefined: all received bytes, including CRC, are delivered.

Decomposition:
- Package usb_rx_pkg holds:
  - state enum type.
  - PID localparams (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL).
  - DATA PID match function.
- One natural sub-module: usb_rx_byte_fifo, a single-clock byte FIFO with push/pop/flush, count and full/empty. The assembler instantiates it once.

Test Plan:
- PID 0xC3 (DATA0), then bytes 0x11, 0x22, 0x33, then pkt_end:
  - Without macro: pkt_valid a cycle later, pkt_pid=3, pkt_len=3; reads return 11, 22, 33.
  - With macro: pkt_len=1, rd_data=11.
- PID 0xC4 (bad complement), bytes, pkt_end -> single pkt_error pulse, pkt_valid never rises, busy low after pkt_end.
- DEPTH=4, PID 0x4B, then 5 bytes -> pkt_error on the 5th push; subsequent pkt_end returns to IDLE; FIFO count=0.
- rcv_error asserted on the same cycle as the 2nd payload write_enable -> DROP, pkt_error pulse; next good packet PID 0xD2 delivers pkt_pid=2, pkt_len=0.
- In READY with 3 bytes, read 1, then pkt_done -> pkt_valid low next cycle; next packet reads from its own first byte, with no stale data.
- Reset asserted mid-PAYLOAD -> all outputs at reset values next cycle; following packet is assembled normally.
